dma_read_engine: RTL and testbench

- Host-side read DMA engine: the stage directly upstream of every consumer that holds a dma_read_interface to_dma modport.
- On a start command it fetches a contiguous run of 512-bit cache lines from host memory, issuing 1-, 2- or 4-line requests.
- Returned lines are forwarded in order on the rx_read channel.
- Status (idle/active/done) is reported back to the controller.

---
 rtl/dma_read_engine_pkg.sv | 44 ++++
 rtl/dma_read_engine_if.sv | 46 ++++
 rtl/dma_read_engine_sizer.sv | 28 ++
 rtl/dma_read_engine.sv | 150 +++++++++++++++
 tb/tb_dma_read_engine.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_read_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_read_engine_pkg                                    |
// | Description : Shared types and helpers for the host read DMA engine. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package dma_read_engine_pkg;

    localparam int c_CLADDR_W = 42;
    localparam int c_CLDATA_W = 512;
    localparam int c_CNT_W    = 32;

    typedef logic [c_CLADDR_W-1:0] t_claddr;
    typedef logic [c_CLDATA_W-1:0] t_cldata;

    typedef struct packed {
        logic idle;
        logic active;
        logic done;
    } t_dma_status;

    typedef enum logic [1:0] {
        LEN1 = 2'b00,
        LEN2 = 2'b01,
        LEN4 = 2'b11
    } t_dma_rlength;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_dmastate;

    function automatic logic [2:0] rlength_lines(input t_dma_rlength len);
        case (len)
            LEN4:    return 3'd4;
            LEN2:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_read_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_read_engine_if                                     |
// | Description : Control, host request/response and rx_read bundle.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface dma_read_engine_if;
    import dma_read_engine_pkg::*;

    logic                 ctrl_start;
    t_claddr              ctrl_addr;
    logic [c_CNT_W-1:0]   ctrl_num_lines;
    logic                 status_idle;
    logic                 status_active;
    logic                 status_done;
    logic                 host_re;
    t_claddr              host_raddr;
    t_dma_rlength         host_rlength;
    logic                 host_almostfull;
    logic                 host_rvalid;
    t_cldata              host_rdata;
    logic                 out_rvalid;
    t_cldata              out_rdata;
    logic                 out_almostfull;

    // master is the engine itself; slave is the controller/host/consumer side
    modport master (
        input  ctrl_start, ctrl_addr, ctrl_num_lines,
        output status_idle, status_active, status_done,
        output host_re, host_raddr, host_rlength,
        input  host_almostfull, host_rvalid, host_rdata,
        output out_rvalid, out_rdata,
        input  out_almostfull
    );

    modport slave (
        output ctrl_start, ctrl_addr, ctrl_num_lines,
        input  status_idle, status_active, status_done,
        input  host_re, host_raddr, host_rlength,
        output host_almostfull, host_rvalid, host_rdata,
        input  out_rvalid, out_rdata,
        output out_almostfull
    );

endinterface
`default_nettype wire

// File: rtl/dma_read_engine_sizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_read_request_sizer                                 |
// | Description : Picks the largest aligned 1/2/4-line request that fits.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module dma_read_request_sizer
    import dma_read_engine_pkg::*;
(
    input  t_claddr            i_addr,
    input  logic [c_CNT_W-1:0] i_remaining,
    input  logic               i_enable,
    output t_dma_rlength       o_rlength,
    output logic [2:0]         o_count
);

    always_comb begin
        o_rlength = LEN1;
        if (i_enable && (i_addr[1:0] == 2'b00) && (i_remaining >= 32'd4)) begin
            o_rlength = LEN4;
        end else if (i_enable && !i_addr[0] && (i_remaining >= 32'd2)) begin
            o_rlength = LEN2;
        end
        o_count = rlength_lines(o_rlength);
    end

endmodule
`default_nettype wire

// File: rtl/dma_read_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_read_engine                                        |
// | Description : Fetches a run of cache lines from host memory and      |
// |               forwards them in order on the rx_read channel.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module dma_read_engine
    import dma_read_engine_pkg::*;
#(
    parameter int MAX_OUTSTANDING   = 64,
    parameter bit ENABLE_MULTI_LINE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    dma_read_engine_if.master dma
);

    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    if ((MAX_OUTSTANDING < 4) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be a power of two and at least 4");
    end

    t_dmastate          r_state;
    t_claddr            r_addr;
    logic [c_CNT_W-1:0] r_num_lines;
    logic [c_CNT_W-1:0] r_requested;
    logic [c_CNT_W-1:0] r_received;
    logic [c_OUT_W-1:0] r_outstanding;
    t_dma_status        r_status;
    logic               r_host_re;
    t_claddr            r_host_raddr;
    t_dma_rlength       r_host_rlength;
    logic               r_out_rvalid;
    t_cldata            r_out_rdata;

    logic [c_CNT_W-1:0] w_remaining;
    t_dma_rlength       w_rlength;
    logic [2:0]         w_count;
    logic [c_OUT_W:0]   w_need;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_rsp;

    assign w_remaining = r_num_lines - r_requested;

    dma_read_request_sizer u_sizer (
        .i_addr      (r_addr),
        .i_remaining (w_remaining),
        .i_enable    (ENABLE_MULTI_LINE),
        .o_rlength   (w_rlength),
        .o_count     (w_count)
    );

    // one extra bit so outstanding+len cannot wrap before the compare
    assign w_need      = {1'b0, r_outstanding} + (c_OUT_W+1)'(w_count);
    assign w_credit_ok = (w_need <= (c_OUT_W+1)'(MAX_OUTSTANDING));
    assign w_issue     = (r_state == ISSUE) && (r_requested != r_num_lines) &&
                         !dma.host_almostfull && !dma.out_almostfull && w_credit_ok;
    assign w_rsp       = dma.host_rvalid && ((r_state == ISSUE) || (r_state == DRAIN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_num_lines    <= '0;
            r_requested    <= '0;
            r_received     <= '0;
            r_outstanding  <= '0;
            r_status       <= '{idle: 1'b1, active: 1'b0, done: 1'b0};
            r_host_re      <= 1'b0;
            r_host_raddr   <= '0;
            r_host_rlength <= LEN1;
        end else begin
            r_host_re <= w_issue;
            if (w_issue) begin
                r_host_raddr   <= r_addr;
                r_host_rlength <= w_rlength;
                r_addr         <= r_addr + t_claddr'(w_count);
                r_requested    <= r_requested + c_CNT_W'(w_count);
            end
            if (w_rsp) begin
                r_received <= r_received + 32'd1;
            end
            r_outstanding <= r_outstanding
                           + (w_issue ? c_OUT_W'(w_count) : c_OUT_W'(0))
                           - (w_rsp ? c_OUT_W'(1) : c_OUT_W'(0));

            case (r_state)
                IDLE: begin
                    if (dma.ctrl_start) begin
                        r_addr        <= dma.ctrl_addr;
                        r_num_lines   <= dma.ctrl_num_lines;
                        r_requested   <= '0;
                        r_received    <= '0;
                        r_outstanding <= '0;
                        if (dma.ctrl_num_lines == 32'd0) begin
                            r_state  <= DONE;
                            r_status <= '{idle: 1'b1, active: 1'b0, done: 1'b1};
                        end else begin
                            r_state  <= ISSUE;
                            r_status <= '{idle: 1'b0, active: 1'b1, done: 1'b0};
                        end
                    end
                end
                ISSUE: begin
                    if (r_requested == r_num_lines) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_received == r_num_lines) begin
                        r_state  <= DONE;
                        r_status <= '{idle: 1'b1, active: 1'b0, done: 1'b1};
                    end
                end
                default: begin
                    r_state         <= IDLE;
                    r_status.idle   <= 1'b1;
                    r_status.active <= 1'b0;
                end
            endcase
        end
    end

    // responses are never throttled here; the consumer keeps headroom for them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_rvalid <= 1'b0;
            r_out_rdata  <= '0;
        end else begin
            r_out_rvalid <= w_rsp;
            if (w_rsp) begin
                r_out_rdata <= dma.host_rdata;
            end
        end
    end

    assign dma.status_idle   = r_status.idle;
    assign dma.status_active = r_status.active;
    assign dma.status_done   = r_status.done;
    assign dma.host_re       = r_host_re;
    assign dma.host_raddr    = r_host_raddr;
    assign dma.host_rlength  = r_host_rlength;
    assign dma.out_rvalid    = r_out_rvalid;
    assign dma.out_rdata     = r_out_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dma_read_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dma_read_engine                                     |
// | Description : Scoreboard bench with a line-level host/consumer model.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_dma_read_engine;
    import dma_read_engine_pkg::*;

    localparam int MAXO = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dma_read_engine_if ifc ();
    dma_read_engine_if ifc1 ();

    dma_read_engine #(.MAX_OUTSTANDING(MAXO), .ENABLE_MULTI_LINE(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .dma(ifc.master));

    dma_read_engine #(.MAX_OUTSTANDING(64), .ENABLE_MULTI_LINE(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .dma(ifc1.master));

    typedef struct packed {
        logic [41:0] addr;
        logic [1:0]  rlen;
    } t_req;

    int n_pass = 0;
    int n_chk  = 0;

    t_req         exp_req[$];
    logic [511:0] exp_out[$];
    logic [41:0]  pending[$];
    int           lines_req = 0;
    int           lines_ret = 0;
    bit           resp_hold = 1'b0;
    bit           stale     = 1'b0;

    logic [41:0]  ml0_next = 42'h101;
    logic [41:0]  ml0_exp  = 42'h101;
    int           ml0_out  = 0;
    logic [41:0]  ml0_pend[$];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [511:0] data_of(input logic [41:0] a);
        return {8{{6'h2A, a, 16'hC3C3}}};
    endfunction

    function automatic int lines_of(input logic [1:0] l);
        if (l == 2'b11) return 4;
        if (l == 2'b01) return 2;
        return 1;
    endfunction

    // Reference model: greedy largest naturally-aligned chunk, address wraps at 2^42
    task automatic push_expected(input logic [41:0] addr, input logic [31:0] n);
        logic [41:0] a;
        longint      rem;
        int          len;
        t_req        r;
        a   = addr;
        rem = longint'(n);
        while (rem > 0) begin
            if ((a % 4 == 0) && rem >= 4)      len = 4;
            else if ((a % 2 == 0) && rem >= 2) len = 2;
            else                               len = 1;
            r.addr = a;
            r.rlen = (len == 4) ? 2'b11 : (len == 2) ? 2'b01 : 2'b00;
            exp_req.push_back(r);
            for (int i = 0; i < len; i++) exp_out.push_back(data_of(a + 42'(i)));
            a   = a + 42'(len);
            rem = rem - len;
        end
    endtask

    // Request monitor: compare against the model, then queue the lines for the host
    initial begin : p_reqmon
        t_req r;
        int   nl;
        forever begin
            @(negedge clk);
            if (reset_n && ifc.host_re) begin
                if (exp_req.size() == 0) begin
                    chk(1'b0, "unexpected_req", 64'(ifc.host_raddr), 64'h0);
                end else begin
                    r = exp_req.pop_front();
                    chk(ifc.host_raddr == r.addr, "req_addr", 64'(ifc.host_raddr), 64'(r.addr));
                    chk(ifc.host_rlength == r.rlen, "req_len", 64'(ifc.host_rlength), 64'(r.rlen));
                end
                nl = lines_of(ifc.host_rlength);
                for (int i = 0; i < nl; i++) pending.push_back(ifc.host_raddr + 42'(i));
                lines_req += nl;
                chk((lines_req - lines_ret) <= MAXO, "credit_limit", 64'(lines_req - lines_ret), 64'(MAXO));
            end
        end
    end

    // Host responder with random gaps; also checks the one-cycle forward latency
    initial begin : p_host
        bit          prev_drv;
        bit          prev_stale;
        logic [41:0] a;
        prev_drv   = 1'b0;
        prev_stale = 1'b0;
        ifc.host_rvalid = 1'b0;
        ifc.host_rdata  = '0;
        forever begin
            @(negedge clk);
            if (reset_n && (ifc.out_rvalid || prev_drv))
                chk(ifc.out_rvalid == (prev_drv && !prev_stale), "out_rvalid_latency",
                    64'(ifc.out_rvalid), 64'(prev_drv && !prev_stale));
            if (stale) begin
                ifc.host_rvalid = 1'b1;
                ifc.host_rdata  = {16{$urandom()}};
                prev_drv   = 1'b1;
                prev_stale = 1'b1;
            end else if (!resp_hold && pending.size() > 0 && $urandom_range(0, 3) != 0) begin
                a = pending.pop_front();
                ifc.host_rvalid = 1'b1;
                ifc.host_rdata  = data_of(a);
                lines_ret++;
                prev_drv   = 1'b1;
                prev_stale = 1'b0;
            end else begin
                ifc.host_rvalid = 1'b0;
                prev_drv   = 1'b0;
                prev_stale = 1'b0;
            end
        end
    end

    initial begin : p_outmon
        logic [511:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && ifc.out_rvalid) begin
                if (exp_out.size() == 0) begin
                    chk(1'b0, "unexpected_out", ifc.out_rdata[63:0], 64'h0);
                end else begin
                    e = exp_out.pop_front();
                    chk(ifc.out_rdata == e, "out_rdata", ifc.out_rdata[63:0], e[63:0]);
                end
            end
        end
    end

    // Single-line-only instance: immediate host, sequential addresses expected
    initial begin : p_dut1
        logic [41:0] a;
        ifc1.host_rvalid = 1'b0;
        ifc1.host_rdata  = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ifc1.host_re) begin
                    chk(ifc1.host_rlength == 2'b00, "ml0_len", 64'(ifc1.host_rlength), 64'h0);
                    chk(ifc1.host_raddr == ml0_next, "ml0_addr", 64'(ifc1.host_raddr), 64'(ml0_next));
                    ml0_pend.push_back(ifc1.host_raddr);
                    ml0_next = ml0_next + 42'd1;
                end
                if (ifc1.out_rvalid) begin
                    chk(ifc1.out_rdata == data_of(ml0_exp), "ml0_data", ifc1.out_rdata[63:0], data_of(ml0_exp)[63:0]);
                    ml0_exp = ml0_exp + 42'd1;
                    ml0_out++;
                end
                if (ml0_pend.size() > 0) begin
                    a = ml0_pend.pop_front();
                    ifc1.host_rvalid = 1'b1;
                    ifc1.host_rdata  = data_of(a);
                end else begin
                    ifc1.host_rvalid = 1'b0;
                end
            end
        end
    end

    task automatic start_xfer(input logic [41:0] addr, input logic [31:0] n, input bit also_ml0);
        push_expected(addr, n);
        @(negedge clk);
        ifc.ctrl_start     = 1'b1;
        ifc.ctrl_addr      = addr;
        ifc.ctrl_num_lines = n;
        if (also_ml0) begin
            ifc1.ctrl_start     = 1'b1;
            ifc1.ctrl_addr      = addr;
            ifc1.ctrl_num_lines = n;
        end
        @(negedge clk);
        ifc.ctrl_start  = 1'b0;
        ifc1.ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while (!(ifc.status_done && ifc.status_idle) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) $display("FAIL %s_timeout: got %0d cycles expected done", nm, cyc);
        chk(cyc < 3000, "done_within_budget", 64'(cyc), 64'd3000);
        chk(exp_req.size() == 0, "all_requests_seen", 64'(exp_req.size()), 64'h0);
        chk(exp_out.size() == 0, "all_lines_forwarded", 64'(exp_out.size()), 64'h0);
    endtask

    initial begin : p_wdog
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int          base;
        int          cnt_re;
        int          cnt_ov;
        logic [41:0] ra;
        ifc.ctrl_start = 1'b0;  ifc.ctrl_addr = '0;  ifc.ctrl_num_lines = '0;
        ifc.host_almostfull = 1'b0;  ifc.out_almostfull = 1'b0;
        ifc1.ctrl_start = 1'b0; ifc1.ctrl_addr = '0; ifc1.ctrl_num_lines = '0;
        ifc1.host_almostfull = 1'b0; ifc1.out_almostfull = 1'b0;
        repeat (3) @(negedge clk);
        chk(ifc.status_idle == 1'b1, "rst_idle", 64'(ifc.status_idle), 64'h1);
        chk({ifc.status_active, ifc.status_done, ifc.host_re, ifc.out_rvalid} == 4'b0,
            "rst_flags", 64'({ifc.status_active, ifc.status_done, ifc.host_re, ifc.out_rvalid}), 64'h0);
        chk(ifc.out_rdata == '0, "rst_rdata", ifc.out_rdata[63:0], 64'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        start_xfer(42'h100, 32'd1, 1'b0);  wait_done("single");
        start_xfer(42'h100, 32'd7, 1'b0);  wait_done("aligned");
        start_xfer(42'h101, 32'd6, 1'b1);  wait_done("unaligned");
        repeat (10) @(negedge clk);
        chk(ml0_out == 6, "ml0_lines", 64'(ml0_out), 64'd6);
        chk(ifc1.status_done == 1'b1, "ml0_done", 64'(ifc1.status_done), 64'h1);

        // Credit limit with responses withheld, then out_almostfull and host_almostfull
        resp_hold = 1'b1;
        base = lines_req;
        start_xfer(42'h200, 32'd32, 1'b0);
        repeat (30) @(negedge clk);
        chk((lines_req - base) == MAXO, "credit_stop", 64'(lines_req - base), 64'(MAXO));
        ifc.out_almostfull = 1'b1;
        resp_hold = 1'b0;
        cnt_re = 0; cnt_ov = 0;
        repeat (12) begin
            @(negedge clk);
            cnt_re += int'(ifc.host_re);
            cnt_ov += int'(ifc.out_rvalid);
        end
        chk(cnt_re == 0, "out_af_no_issue", 64'(cnt_re), 64'h0);
        chk(cnt_ov > 0, "out_af_inflight_forwarded", 64'(cnt_ov), 64'h1);
        ifc.out_almostfull = 1'b0;
        repeat (3) @(negedge clk);
        ifc.host_almostfull = 1'b1;
        cnt_re = 0;
        repeat (10) begin
            @(negedge clk);
            cnt_re += int'(ifc.host_re);
        end
        chk(cnt_re == 0, "host_af_no_issue", 64'(cnt_re), 64'h0);
        ifc.host_almostfull = 1'b0;
        wait_done("credit");

        start_xfer(42'h300, 32'd0, 1'b0);
        chk(ifc.status_done == 1'b1, "zero_done", 64'(ifc.status_done), 64'h1);
        chk(ifc.status_active == 1'b0, "zero_not_active", 64'(ifc.status_active), 64'h0);
        wait_done("zero");

        start_xfer(42'h400, 32'd12, 1'b0);
        repeat (3) @(negedge clk);
        ifc.ctrl_start = 1'b1; ifc.ctrl_addr = 42'h999; ifc.ctrl_num_lines = 32'd5;
        @(negedge clk);
        ifc.ctrl_start = 1'b0;
        wait_done("start_ignored");

        start_xfer(42'h3FF_FFFF_FFFE, 32'd4, 1'b0);  wait_done("wrap");

        for (int k = 0; k < 6; k++) begin
            ra = 42'({$urandom(), $urandom()});
            start_xfer(ra, 32'($urandom_range(1, 40)), 1'b0);
            wait_done("random");
        end

        // Reset mid-transfer with stale host responses
        resp_hold = 1'b1;
        start_xfer(42'h500, 32'd20, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        stale = 1'b1;
        chk(ifc.status_idle == 1'b1, "midrst_idle", 64'(ifc.status_idle), 64'h1);
        chk({ifc.status_active, ifc.status_done, ifc.host_re, ifc.out_rvalid} == 4'b0,
            "midrst_flags", 64'({ifc.status_active, ifc.status_done, ifc.host_re, ifc.out_rvalid}), 64'h0);
        chk(ifc.out_rdata == '0, "midrst_rdata", ifc.out_rdata[63:0], 64'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        cnt_ov = 0;
        repeat (4) begin
            @(negedge clk);
            cnt_ov += int'(ifc.out_rvalid);
        end
        chk(cnt_ov == 0, "stale_ignored", 64'(cnt_ov), 64'h0);
        chk(ifc.status_idle == 1'b1 && ifc.status_active == 1'b0, "stale_still_idle",
            64'({ifc.status_idle, ifc.status_active}), 64'h2);
        stale = 1'b0;
        pending.delete();
        exp_req.delete();
        exp_out.delete();
        lines_req = 0;
        lines_ret = 0;
        @(negedge clk);
        resp_hold = 1'b0;
        start_xfer(42'h600, 32'd5, 1'b0);  wait_done("after_reset");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
